// File: rtl/detector_scheduler_pkg.sv
// Shared types and constants for the round-robin pattern-detector scheduler.
package detector_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int                     DEF_PAT_LEN = 6;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 6'b101101;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/detector_scheduler_window_matcher.sv
// Sliding PAT_LEN-bit window with a valid-bit count; match is decided on the
// window as it will look after the current shift.
module detector_scheduler_window_matcher
    import detector_scheduler_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_in,
    input  logic shift_en,
    input  logic clear,
    output logic match
);

    localparam int VCW = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] win_q, win_d, win_next;
    logic [VCW-1:0]     vcnt_q, vcnt_d;

    assign win_next = {win_q[PAT_LEN-2:0], bit_in};

    // The incoming bit is the PAT_LEN-th (or later) once PAT_LEN-1 are already held.
    assign match = shift_en && !clear
                   && (vcnt_q >= VCW'(PAT_LEN - 1))
                   && (win_next == PATTERN);

    always_comb begin
        win_d  = win_q;
        vcnt_d = vcnt_q;
        if (clear) begin
            win_d  = '0;
            vcnt_d = '0;
        end else if (shift_en) begin
            win_d = win_next;
            if (vcnt_q != VCW'(PAT_LEN)) begin
                vcnt_d = vcnt_q + VCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q  <= '0;
            vcnt_q <= '0;
        end else begin
            win_q  <= win_d;
            vcnt_q <= vcnt_d;
        end
    end

endmodule

// File: rtl/detector_scheduler.sv
// Round-robin arbiter that streams one granted job word MSB-first through a
// shared window matcher and reports the per-job match count.
module detector_scheduler
    import detector_scheduler_pkg::*;
#(
    parameter int                 NREQ    = 4,
    parameter int                 WORD    = 16,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 CNT_W   = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WORD-1:0]        data,
    output logic [NREQ-1:0]             grant,
    output logic                        busy,
    output logic                        hit,
    output logic                        done,
    output logic [id_width(NREQ)-1:0]   done_id,
    output logic [CNT_W-1:0]            match_cnt
);

    localparam int IDW = id_width(NREQ);
    localparam int BCW = $clog2(WORD + 1);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [WORD-1:0]  shift_q, shift_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] job_cnt_q, job_cnt_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             hit_q, hit_d;
    logic             done_q, done_d;

    logic             sel_vld;
    logic [IDW-1:0]   sel;
    logic             win_clear, win_shift, win_match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // First asserted request strictly after the last grant, wrapping around.
    always_comb begin
        logic [IDW-1:0] idx;
        sel_vld = 1'b0;
        sel     = '0;
        idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(rr_q) + i) % NREQ);
            if (!sel_vld && req[idx]) begin
                sel_vld = 1'b1;
                sel     = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = '0;
        shift_d     = shift_q;
        rr_d        = rr_q;
        cur_id_d    = cur_id_q;
        bit_cnt_d   = bit_cnt_q;
        job_cnt_d   = job_cnt_q;
        hit_d       = 1'b0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        win_clear   = 1'b0;
        win_shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    grant_d   = NREQ'(1) << sel;
                    shift_d   = WORD'(data >> (sel * WORD));
                    cur_id_d  = sel;
                    rr_d      = sel;
                    bit_cnt_d = '0;
                    job_cnt_d = '0;
                    win_clear = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                win_shift = 1'b1;
                shift_d   = {shift_q[WORD-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BCW'(1);
                hit_d     = win_match;
                if (win_match) begin
                    job_cnt_d = sat_inc(job_cnt_q);
                end
                // Last bit: report the count including a hit on this very bit.
                if (bit_cnt_q == BCW'(WORD - 1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    done_id_d   = cur_id_q;
                    match_cnt_d = job_cnt_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= IDW'(NREQ - 1);
            cur_id_q    <= '0;
            bit_cnt_q   <= '0;
            job_cnt_q   <= '0;
            hit_q       <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            cur_id_q    <= cur_id_d;
            bit_cnt_q   <= bit_cnt_d;
            job_cnt_q   <= job_cnt_d;
            hit_q       <= hit_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    // Job word is pure data and is always reloaded at grant.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    detector_scheduler_window_matcher #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_matcher (
        .clk      (clk),
        .reset    (reset),
        .bit_in   (shift_q[WORD-1]),
        .shift_en (win_shift),
        .clear    (win_clear),
        .match    (win_match)
    );

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign hit       = hit_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;

endmodule
